// File: rtl/sram_arb_ctrl.sv
// Round-robin two-port arbiter/sequencer for a single-port SRAM with registered SRAM-side signals.
// Optional address range check enabled by defining SRAM_RANGE_CHK_EN.
module sram_arb_ctrl #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned AWIDTH = 30,
  parameter int unsigned DEPTH  = 2048
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_rw,
  input  logic [AWIDTH-1:0] p0_addr,
  input  logic [WIDTH-1:0]  p0_wdata,
  output logic              p0_gnt,
  output logic              p0_ack,
  output logic [WIDTH-1:0]  p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_rw,
  input  logic [AWIDTH-1:0] p1_addr,
  input  logic [WIDTH-1:0]  p1_wdata,
  output logic              p1_gnt,
  output logic              p1_ack,
  output logic [WIDTH-1:0]  p1_rdata,
  output logic              p1_err,
  output logic              mem_cs,
  output logic              mem_rw,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  input  logic [WIDTH-1:0]  mem_dout
);

`ifdef SRAM_RANGE_CHK_EN
  localparam logic RangeChkEn = 1'b1;
`else
  localparam logic RangeChkEn = 1'b0;
`endif

  localparam logic [AWIDTH-1:0] DepthA = AWIDTH'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              op_rw_q, op_rw_d;
  logic              oor_q, oor_d;
  logic              mem_cs_q, mem_cs_d;
  logic              mem_rw_q, mem_rw_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_din_q, mem_din_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [WIDTH-1:0]  p0_rdata_q, p0_rdata_d;
  logic [WIDTH-1:0]  p1_rdata_q, p1_rdata_d;
  logic              p0_err_q, p0_err_d;
  logic              p1_err_q, p1_err_d;

  logic              arb_en_c;
  logic              any_req_c;
  logic              win_c;
  logic              sel_rw_c;
  logic [AWIDTH-1:0] sel_addr_c;
  logic [WIDTH-1:0]  sel_wdata_c;
  logic              oor_c;

  // Winner: requester at the pointer if requesting, else the other one.
  always_comb begin
    arb_en_c    = (state_q != ACC);
    any_req_c   = p0_req | p1_req;
    win_c       = ptr_q ? p1_req : ~p0_req;
    sel_rw_c    = win_c ? p1_rw    : p0_rw;
    sel_addr_c  = win_c ? p1_addr  : p0_addr;
    sel_wdata_c = win_c ? p1_wdata : p0_wdata;
    oor_c       = RangeChkEn & (sel_addr_c >= DepthA);
  end

  assign p0_gnt = arb_en_c & p0_req & ~win_c;
  assign p1_gnt = arb_en_c & p1_req &  win_c;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    op_rw_d    = op_rw_q;
    oor_d      = oor_q;
    mem_cs_d   = 1'b0;
    mem_rw_d   = mem_rw_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    p0_err_d   = 1'b0;
    p1_err_d   = 1'b0;

    case (state_q)
      IDLE, RESP: begin
        if (any_req_c) begin
          state_d = ACC;
          owner_d = win_c;
          ptr_d   = ~win_c;
          op_rw_d = sel_rw_c;
          oor_d   = oor_c;
          // Out-of-range requests never touch the SRAM pins.
          if (!oor_c) begin
            mem_cs_d   = 1'b1;
            mem_rw_d   = sel_rw_c;
            mem_addr_d = sel_addr_c;
            mem_din_d  = sel_wdata_c;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        state_d = RESP;
        if (!owner_q) begin
          p0_ack_d = 1'b1;
          p0_err_d = oor_q;
          if (op_rw_q) p0_rdata_d = oor_q ? '0 : mem_dout;
        end else begin
          p1_ack_d = 1'b1;
          p1_err_d = oor_q;
          if (op_rw_q) p1_rdata_d = oor_q ? '0 : mem_dout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      owner_q    <= 1'b0;
      op_rw_q    <= 1'b1;
      oor_q      <= 1'b0;
      mem_cs_q   <= 1'b0;
      mem_rw_q   <= 1'b1;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= '0;
      p1_rdata_q <= '0;
      p0_err_q   <= 1'b0;
      p1_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      op_rw_q    <= op_rw_d;
      oor_q      <= oor_d;
      mem_cs_q   <= mem_cs_d;
      mem_rw_q   <= mem_rw_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
      p0_err_q   <= p0_err_d;
      p1_err_q   <= p1_err_d;
    end
  end

  assign mem_cs   = mem_cs_q;
  assign mem_rw   = mem_rw_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;
  assign p0_err   = p0_err_q;
  assign p1_err   = p1_err_q;

endmodule
